// File: rtl/dec_pkg.sv
// Shared types and helpers for the N-to-2^N one-hot decoder with self-test.
package dec_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam int unsigned MAX_N       = 8;
  localparam int unsigned MAX_W       = 1 << MAX_N;
  localparam int unsigned FAULT_CNT_W = 8;

  function automatic logic [MAX_W-1:0] onehot(input logic [MAX_N-1:0] code, input logic en);
    logic [MAX_W-1:0] w;
    w = '0;
    if (en) w[code] = 1'b1;
    return w;
  endfunction

  function automatic longint unsigned fault_cnt_sat(input int unsigned cw);
    return (64'd1 << cw) - 64'd1;
  endfunction

endpackage

// File: rtl/dec_onehot_chk.sv
// On-line checker: flags registered words that differ from the ideal decode.
module dec_onehot_chk import dec_pkg::*; #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [(1<<N)-1:0] i_word,
  input  logic [(1<<N)-1:0] i_ideal,
  input  logic [N-1:0]      i_code,
  input  logic              i_clr,
  output logic              o_fault,
  output logic [N-1:0]      o_fault_code,
  output logic [CW-1:0]     o_fault_cnt
);

  localparam logic [CW-1:0] SAT = CW'(fault_cnt_sat(CW));

  logic          r_fault;
  logic [N-1:0]  r_code;
  logic [CW-1:0] r_cnt;
  logic          w_mis;
  logic          w_fault_base;
  logic [CW-1:0] w_cnt_base;

  // Clear is folded into the base values so a same-cycle mismatch starts from a clean slate.
  always_comb begin
    w_mis        = i_load && (i_word != i_ideal);
    w_fault_base = i_clr ? 1'b0 : r_fault;
    w_cnt_base   = i_clr ? '0 : r_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
      r_code  <= '0;
      r_cnt   <= '0;
    end else if (w_mis) begin
      r_fault <= 1'b1;
      if (!w_fault_base) r_code <= i_code;
      r_cnt   <= (w_cnt_base != SAT) ? w_cnt_base + CW'(1) : w_cnt_base;
    end else if (i_clr) begin
      r_fault <= 1'b0;
      r_code  <= '0;
      r_cnt   <= '0;
    end
  end

  assign o_fault      = r_fault;
  assign o_fault_code = r_code;
  assign o_fault_cnt  = r_cnt;

endmodule

// File: rtl/dec_nx_bist.sv
// Registered N-to-2^N one-hot decoder with valid/ready input and a self-test sweep.
module dec_nx_bist import dec_pkg::*; #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = FAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  input  logic [N-1:0]      A,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [(1<<N)-1:0] fi_mask,
  input  logic              clr_fault,
  output logic [(1<<N)-1:0] D,
  output logic              d_valid,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [N-1:0]      fault_code,
  output logic [CW-1:0]     fault_cnt
);

  localparam int unsigned W = 1 << N;

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_ctr, w_ctr_nxt, w_code;
  logic         w_issue;
  logic [W-1:0] w_ideal, w_word, r_d;
  logic         r_dvalid;

  always_comb begin
    w_state_nxt = r_state;
    w_ctr_nxt   = r_ctr;
    w_code      = A;
    w_issue     = 1'b0;
    in_ready    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = ~mode;
        w_issue  = in_valid & ~mode;
        if (start && mode) begin
          w_state_nxt = SWEEP;
          w_ctr_nxt   = '0;
        end
      end
      SWEEP: begin
        w_issue = 1'b1;
        w_code  = r_ctr;
        if (r_ctr == '1) w_state_nxt = DONE;
        else             w_ctr_nxt   = r_ctr + N'(1);
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ideal = W'(onehot(MAX_N'(w_code), en));
    w_word  = w_ideal ^ fi_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ctr    <= '0;
      r_d      <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctr    <= w_ctr_nxt;
      r_dvalid <= w_issue;
      if (w_issue) r_d <= w_word;
    end
  end

  dec_onehot_chk #(.N(N), .CW(CW)) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_issue),
    .i_word       (w_word),
    .i_ideal      (w_ideal),
    .i_code       (w_code),
    .i_clr        (clr_fault),
    .o_fault      (fault),
    .o_fault_code (fault_code),
    .o_fault_cnt  (fault_cnt)
  );

  assign D       = r_d;
  assign d_valid = r_dvalid;
  assign busy    = (r_state == SWEEP);
  assign done    = (r_state == DONE);

endmodule

// File: doc/dec_nx_bist.md
Name: dec_nx_bist

Overview:
- Parametrised registered N-to-2^N one-hot decoder, the successor to the fixed 4x16 decoders built from 3x8 stages.
- Adds a valid/ready input handshake and a built-in self-test sweep that walks every code.
- Adds an on-line checker that flags any output word differing from the ideal decode, with a fault-injection port so the checker itself is verifiable.
- Sits between address/select logic and downstream one-hot consumers.

Parameters:
- N, 4, input code width; output width is 2^N.
- CW, 8, width of the saturating fault counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  decode enable; 0 forces ideal decode to all-zeros.
- mode  in  1  0 = direct decode, 1 = sweep self-test.
- start  in  1  one-cycle pulse; starts a sweep when idle and mode=1.
- A  in  N  input code in direct mode.
- in_valid  in  1  A is valid.
- in_ready  out  1  block accepts A this cycle.
- fi_mask  in  2^N  fault injection, XORed onto the decoded word.
- clr_fault  in  1  clears fault, fault_code and fault_cnt.
- D  out  2^N  registered decoded word.
- d_valid  out  1  D updated this cycle.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at end of sweep.
- fault  out  1  sticky mismatch flag.
- fault_code  out  N  code of the first mismatching word since the last clear.
- fault_cnt  out  CW  saturating count of mismatching words.

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0 (D, d_valid, busy, done, fault, fault_code, fault_cnt); in_ready takes its combinational IDLE value once reset releases. Reset mid-sweep aborts the sweep with no done pulse.
- Ideal decode of code c: ideal(c) = en ? (1<<c) : 0. Emitted word: ideal(c) ^ fi_mask, sampled in the same cycle as c.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - in_ready = (mode==0).
  - Transfer when in_valid && in_ready. Next cycle: D = word, d_valid=1.
  - With no transfer, d_valid=0 and D holds its value.
  - start && mode==1: go to SWEEP with counter=0. Any direct transfer in that cycle is blocked because in_ready=0.
- SWEEP:
  - busy=1, in_ready=0.
  - Each cycle, word for the counter value is registered to D with d_valid=1 the next cycle; counter increments.
  - When counter==2^N-1 is issued, go to DONE. Counter does not wrap.
  - start, mode and in_valid are ignored; en and fi_mask are sampled every cycle.
- DONE: done=1 for exactly one cycle, busy=0, in_ready=0; return to IDLE.
- Latency: code accepted at cycle t appears on D at t+1. A sweep issues 2^N words on consecutive cycles; done asserts the cycle after the last word is registered.
- Checker:
  - Each registered word is compared against ideal(c) of the same code, i.e. a mismatch iff fi_mask!=0.
  - On mismatch: fault=1 (sticky); fault_cnt increments, saturating at 2^CW-1; fault_code is captured only when fault was 0.
  - Flags update in the same cycle as D.
- clr_fault in the same cycle as a new mismatch: the clear is applied first, then the mismatch. Result: fault=1, fault_cnt=1, fault_code=new code.

Decomposition:
- Package dec_pkg holds:
  - state enum {IDLE, SWEEP, DONE};
  - function onehot(code, en) returning the ideal word;
  - constant for the fault_cnt saturation value.
- Sub-module dec_onehot_chk: compares word against ideal and drives fault, fault_code, fault_cnt (including saturation and clear priority).
- Top module holds the FSM, counter, handshake and D register.

Test Plan:
- Reset: rst_n low mid-sweep at counter=5 -> all outputs 0 immediately; no done pulse; after release in_ready=1 with mode=0.
- Direct decode, N=4: A=9, in_valid=1, en=1, fi_mask=0 -> next cycle D=16'h0200, d_valid=1, fault=0. With en=0 -> D=16'h0000.
- Sweep, N=4, fi_mask=0: start pulse -> D=0x0001, 0x0002, ... 0x8000 on 16 consecutive cycles; busy=1 throughout; done pulses on the 17th cycle; fault=0.
- Fault injection: sweep with fi_mask=16'h0010 only while counter in {3,7} -> fault=1, fault_code=3, fault_cnt=2.
- Saturation and clear, CW=2: 5 faulted direct transfers -> fault_cnt=3. clr_fault asserted together with a faulted transfer of A=6 -> fault_cnt=1, fault_code=6.
- Handshake: mode=0, in_valid held through a start pulse with mode toggled to 1 -> in_ready=0 in the start cycle, no transfer while busy, and start during SWEEP is ignored.
